compressor_5to2_checker: RTL and testbench
==========================================

COMPRESSOR_5TO2_CHECKER -- requirements
Module: compressor_5to2_checker

Interface
REQ-001 Parameter: LAT, default 1, DUT output sampling delay in clock cycles after a vector is driven; legal range 1..4.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a full exhaustive sweep; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminate a sweep in progress.
REQ-006 Port: vec_out  output  7  stimulus driven to the compressor, ordered {x1,x2,x3,x4,x5,Cin1,Cin2}, with x1 as the MSB.
REQ-007 Port: dut_sum, dut_carry, dut_cout1, dut_cout2  input  1 each  compressor outputs under check.
REQ-008 Port: busy  output  1  high in RUN and DRAIN.
REQ-009 Port: done  output  1  one-cycle pulse when a sweep completes normally.
REQ-010 Port: pass  output  1  high when the last completed sweep found zero errors.
REQ-011 Port: err_count  output  8  number of mismatching vectors in the current or last sweep.
REQ-012 Port: fail_valid / fail_vec  output  1 / 7  marks and holds the first failing vector.
REQ-013 Port: aborted  output  1  high when the last sweep ended by abort.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE SHALL move to RUN when start=1 and abort=0; the same transition SHALL clear err_count, fail_valid, fail_vec, pass and aborted, and SHALL load vec_out=0.
REQ-016 In RUN, vec_out SHALL increment by 1 each cycle, from 0 to 127; the cycle that presents 127 SHALL be followed by DRAIN.
REQ-017 DRAIN SHALL last exactly LAT cycles, then move to DONE; vec_out SHALL hold 127 in DRAIN.
REQ-018 DONE SHALL last one cycle, assert done=1 and pass=(err_count==0), then move to IDLE.
REQ-019 A LAT-deep shift register SHALL delay each vector with a valid bit, so that the DUT outputs sampled in a cycle are checked against the vector driven LAT cycles earlier.
REQ-020 Check rule: popcount(vector) SHALL equal dut_sum + 2*(dut_carry + dut_cout1 + dut_cout2), computed at 4-bit width with no truncation; any inequality is a mismatch.
REQ-021 Each mismatch SHALL increment err_count by 1; the maximum is 128, so no wrap occurs.
REQ-022 On the first mismatch of a sweep, fail_vec SHALL capture the delayed vector and fail_valid SHALL set; later mismatches SHALL NOT change either.
REQ-023 A sweep SHALL take exactly 128+LAT+1 cycles from the start-accept edge to the done pulse.
REQ-024 start asserted while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 abort=1 in RUN or DRAIN SHALL go to IDLE on the next edge and set aborted=1; done SHALL NOT pulse, pass SHALL stay 0, and err_count / fail_* SHALL hold their partial values.
REQ-026 abort in IDLE or DONE SHALL have no effect; if start and abort are both high in IDLE, abort wins and no sweep starts.
REQ-027 The delay-line valid bits SHALL clear on abort, so no check occurs after leaving RUN/DRAIN.
REQ-028 In IDLE, vec_out SHALL hold its last value and no checks SHALL occur.

Reset
REQ-029 rst=1 SHALL force IDLE and set vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, aborted=0, and clear all delay-line valid bits.
REQ-030 rst SHALL take priority over start and abort, and SHALL take effect in every state, including mid-RUN; the interrupted sweep leaves no residue.

Verification
REQ-031 Golden compressor, LAT=1, one start pulse -> done 130 cycles after acceptance, pass=1, err_count=0, fail_valid=0.
REQ-032 DUT with dut_sum stuck at 0 -> err_count=64, fail_vec=7'd1, pass=0.
REQ-033 Golden DUT with outputs registered one extra stage, LAT=2 -> pass=1, with done at 131 cycles; the same DUT with LAT=1 -> pass=0.
REQ-034 abort when vec_out=40 -> IDLE next cycle, aborted=1, no done pulse; a subsequent start -> full clean sweep, pass=1, aborted=0.
REQ-035 rst mid-RUN at vec_out=90 -> all outputs at reset values on the next cycle; start pulses during busy are ignored, verified by a single done pulse.
REQ-036 start and abort asserted together in IDLE -> busy stays 0 and vec_out stays 0.

Source files
------------

// File: rtl/compressor_5to2_checker.sv
// compressor_5to2_checker: exhaustive self-test sequencer for a 5:2 compressor.
// Drives all 128 input vectors, delays each one by LAT cycles alongside a valid
// bit, and compares the compressor's weighted outputs against the vector's
// popcount. It reports the error count, the first failing vector and pass/abort
// status.
module compressor_5to2_checker #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [6:0] vec_out,
  input  logic       dut_sum,
  input  logic       dut_carry,
  input  logic       dut_cout1,
  input  logic       dut_cout2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [6:0] fail_vec,
  output logic       aborted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           drain_q, drain_d;
  logic [6:0]           vec_q, vec_d;
  logic [LAT-1:0]       pv_q, pv_d;
  logic [LAT-1:0][6:0]  pvec_q, pvec_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [7:0]           err_q, err_d;
  logic                 fail_valid_q, fail_valid_d;
  logic [6:0]           fail_vec_q, fail_vec_d;
  logic                 aborted_q, aborted_d;

  logic active_s;
  logic start_acc_s;
  logic step_s;
  logic new_valid_s;
  logic mismatch_s;

  // Number of ones in a 7-bit vector (0..7).
  function automatic logic [3:0] popcount7(input logic [6:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 7; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Arithmetic value represented by the compressor outputs: sum + 2*(carries).
  function automatic logic [3:0] out_weight(input logic s, input logic c,
                                            input logic c1, input logic c2);
    logic [1:0] carries;
    carries = {1'b0, c} + {1'b0, c1} + {1'b0, c2};
    return {3'd0, s} + {1'b0, carries, 1'b0};
  endfunction

  // Next-state logic for the sweep controller.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (vec_q == 7'd127) begin
          state_d = S_DRAIN;
          drain_d = 3'd0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drain_q == 3'(LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered-output next values: vector counter, delay line, checking.
  always_comb begin
    active_s     = (state_q == S_RUN) || (state_q == S_DRAIN);
    start_acc_s  = (state_q == S_IDLE) && start && !abort;
    step_s       = (state_q == S_RUN) && !abort && (vec_q != 7'd127);
    new_valid_s  = start_acc_s || step_s;
    // Checks are suppressed on the abort edge so an aborted sweep stops counting at once.
    mismatch_s   = active_s && !abort && pv_q[LAT-1] &&
                   (popcount7(pvec_q[LAT-1]) !=
                    out_weight(dut_sum, dut_carry, dut_cout1, dut_cout2));

    vec_d        = vec_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    pass_d       = pass_q;
    aborted_d    = aborted_q;
    done_d       = (state_q == S_DONE);
    busy_d       = (state_d == S_RUN) || (state_d == S_DRAIN);

    if (start_acc_s) begin
      vec_d = 7'd0;
    end else if (step_s) begin
      vec_d = vec_q + 7'd1;
    end else begin
      vec_d = vec_q;
    end

    // Stage 0 holds the vector currently on vec_out; stage LAT-1 is the one being checked.
    if (active_s && abort) begin
      pv_d = '0;
    end else begin
      pv_d[0] = new_valid_s;
      for (int i = 1; i < LAT; i++) begin
        pv_d[i] = pv_q[i-1];
      end
    end
    pvec_d[0] = vec_d;
    for (int i = 1; i < LAT; i++) begin
      pvec_d[i] = pvec_q[i-1];
    end

    if (start_acc_s) begin
      err_d        = 8'd0;
      fail_valid_d = 1'b0;
      fail_vec_d   = 7'd0;
      pass_d       = 1'b0;
      aborted_d    = 1'b0;
    end else if (mismatch_s) begin
      err_d = err_q + 8'd1;
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_vec_d   = pvec_q[LAT-1];
      end else begin
        fail_valid_d = fail_valid_q;
      end
    end else if (active_s && abort) begin
      aborted_d = 1'b1;
    end else if (state_q == S_DONE) begin
      pass_d = (err_q == 8'd0);
    end else begin
      err_d = err_q;
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drain_q      <= 3'd0;
      vec_q        <= 7'd0;
      pv_q         <= '0;
      pvec_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 8'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 7'd0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      vec_q        <= vec_d;
      pv_q         <= pv_d;
      pvec_q       <= pvec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      aborted_q    <= aborted_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_compressor_5to2_checker.sv
// Testbench for compressor_5to2_checker: two instances (LAT=1 and LAT=2) driven
// by a behavioural compressor model with selectable faults; expected sweep
// results are queued at launch and checked by a monitor on done/aborted.
module tb_compressor_5to2_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  logic [6:0] vec1, vec2, fvec1, fvec2;
  logic [7:0] err1, err2;
  logic busy1, done1, pass1, fv1, ab1;
  logic busy2, done2, pass2, fv2, ab2;
  logic [3:0] comb1, comb2, reg1_q, reg2_q, rsp1, rsp2;

  // mode 0: golden, 1: sum stuck at 0, 2: golden with one register stage, 3: random faults
  int mode;
  bit fmask [128];
  logic [3:0] fpat [128];
  int last_vec;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_abort;
    int err;
    bit fv;
    int fvec;
    bit pass;
    int acc;
    int lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // Compressor response {sum, carry, cout1, cout2} for vector v under the current mode.
  function automatic logic [3:0] model_resp(int md, int v);
    int p, h;
    logic [3:0] r;
    p = $countones(v);
    h = p / 2;
    r[3] = (p % 2 == 1);
    r[2] = (h >= 1);
    r[1] = (h >= 2);
    r[0] = (h >= 3);
    if (md == 1) r[3] = 1'b0;
    if (md == 3 && fmask[v]) r = r ^ fpat[v];
    return r;
  endfunction

  function automatic int weight(logic [3:0] r);
    return int'(r[3]) + 2 * (int'(r[2]) + int'(r[1]) + int'(r[0]));
  endfunction

  // Sweep outcome: the outputs checked against vector k come from the vector
  // presented (lat-1-dly) cycles later, clamped to the held endpoints.
  function automatic exp_t predict(int lat, int dly, int lastv, int acc);
    exp_t e;
    int s, sv;
    e.is_abort = 1'b0; e.err = 0; e.fv = 1'b0; e.fvec = 0; e.acc = acc; e.lat = lat;
    for (int k = 0; k < 128; k++) begin
      s = k + lat - 1 - dly;
      sv = (s < 0) ? lastv : ((s > 127) ? 127 : s);
      if (weight(model_resp(mode, sv)) != $countones(k)) begin
        e.err++;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.fvec = k;
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  always_comb comb1 = model_resp(mode, int'(vec1));
  always_comb comb2 = model_resp(mode, int'(vec2));
  always @(posedge clk) reg1_q <= comb1;
  always @(posedge clk) reg2_q <= comb2;
  assign rsp1 = (mode == 2) ? reg1_q : comb1;
  assign rsp2 = (mode == 2) ? reg2_q : comb2;

  always @(posedge clk) cyc <= cyc + 1;

  compressor_5to2_checker #(.LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec1),
    .dut_sum(rsp1[3]), .dut_carry(rsp1[2]), .dut_cout1(rsp1[1]), .dut_cout2(rsp1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_vec(fvec1), .aborted(ab1)
  );

  compressor_5to2_checker #(.LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec2),
    .dut_sum(rsp2[3]), .dut_carry(rsp2[2]), .dut_cout1(rsp2[1]), .dut_cout2(rsp2[0]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_vec(fvec2), .aborted(ab2)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected record when an instance signals done or abort.
  bit ab1_prev = 1'b0;
  bit ab2_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("done_kind1", 0, int'(e.is_abort));
        chk("err_count1", int'(err1), e.err);
        chk("pass1", int'(pass1), int'(e.pass));
        chk("fail_valid1", int'(fv1), int'(e.fv));
        chk("fail_vec1", int'(fvec1), e.fvec);
        chk("done_latency1", cyc - e.acc, 128 + e.lat + 1);
      end
    end
    if (ab1 && !ab1_prev) begin
      if (q1.size() == 0) begin
        chk("unexpected_abort1", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("abort_kind1", 1, int'(e.is_abort));
        chk("abort_busy1", int'(busy1), 0);
        chk("abort_pass1", int'(pass1), 0);
        chk("abort_done1", int'(done1), 0);
      end
    end
    if (done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("done_kind2", 0, int'(e.is_abort));
        chk("err_count2", int'(err2), e.err);
        chk("pass2", int'(pass2), int'(e.pass));
        chk("fail_valid2", int'(fv2), int'(e.fv));
        chk("fail_vec2", int'(fvec2), e.fvec);
        chk("done_latency2", cyc - e.acc, 128 + e.lat + 1);
      end
    end
    if (ab2 && !ab2_prev) begin
      if (q2.size() == 0) begin
        chk("unexpected_abort2", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("abort_kind2", 1, int'(e.is_abort));
        chk("abort_busy2", int'(busy2), 0);
        chk("abort_pass2", int'(pass2), 0);
        chk("abort_done2", int'(done2), 0);
      end
    end
    ab1_prev <= ab1;
    ab2_prev <= ab2;
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_vec1"}, int'(vec1), 0);
    chk({tag, "_busy1"}, int'(busy1), 0);
    chk({tag, "_done1"}, int'(done1), 0);
    chk({tag, "_pass1"}, int'(pass1), 0);
    chk({tag, "_err1"}, int'(err1), 0);
    chk({tag, "_fv1"}, int'(fv1), 0);
    chk({tag, "_fvec1"}, int'(fvec1), 0);
    chk({tag, "_ab1"}, int'(ab1), 0);
    chk({tag, "_vec2"}, int'(vec2), 0);
    chk({tag, "_busy2"}, int'(busy2), 0);
    chk({tag, "_err2"}, int'(err2), 0);
    chk({tag, "_ab2"}, int'(ab2), 0);
  endtask

  // Select a fault mode, let the registered model settle, queue predictions, pulse start.
  task automatic launch(int md);
    int dly;
    mode = md;
    if (md == 3) begin
      for (int v = 0; v < 128; v++) begin
        fmask[v] = ($urandom_range(0, 11) == 0);
        fpat[v]  = 4'($urandom_range(1, 15));
      end
    end
    repeat (2) @(negedge clk);
    dly = (md == 2) ? 1 : 0;
    q1.push_back(predict(1, dly, last_vec, cyc + 1));
    q2.push_back(predict(2, dly, last_vec, cyc + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for both sweeps to be reported; optionally poke start while busy / in DONE.
  task automatic wait_sweeps(bit poke);
    int n;
    bit prev_busy1;
    bit poked_done;
    n = 0;
    prev_busy1 = 1'b1;
    poked_done = 1'b0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
      start = 1'b0;
      if (poke && busy1 && busy2 && ($urandom_range(0, 7) == 0)) start = 1'b1;
      if (poke && !poked_done && prev_busy1 && !busy1 && !done1) begin
        start = 1'b1;
        poked_done = 1'b1;
      end
      prev_busy1 = busy1;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 400) chk("sweep_timeout", n, 0);
    last_vec = 127;
    repeat (3) @(negedge clk);
    chk("idle_after_sweep1", int'(busy1), 0);
    chk("idle_after_sweep2", int'(busy2), 0);
  endtask

  task automatic wait_vec(int target);
    int n;
    n = 0;
    while (int'(vec1) != target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("wait_vec_timeout", n, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t a;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; last_vec = 0;
    for (int v = 0; v < 128; v++) begin
      fmask[v] = 1'b0;
      fpat[v] = 4'd0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // start and abort together in IDLE: nothing starts
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy1", int'(busy1), 0);
    chk("start_abort_vec1", int'(vec1), 0);
    chk("start_abort_busy2", int'(busy2), 0);
    chk("start_abort_ab1", int'(ab1), 0);

    // golden sweep with stray start pulses while busy and in DONE
    launch(0);
    wait_sweeps(1'b1);
    // sum stuck at 0
    launch(1);
    wait_sweeps(1'b0);
    // registered golden DUT: passes only with LAT=2
    launch(2);
    wait_sweeps(1'b0);
    // randomized fault patterns
    for (int r = 0; r < 3; r++) begin
      launch(3);
      wait_sweeps(1'b1);
    end

    // reset mid-run
    launch(1);
    wait_vec(90);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrun_reset");
    rst = 1'b0;
    q1.delete();
    q2.delete();
    last_vec = 0;
    repeat (4) @(negedge clk);
    chk("post_reset_busy1", int'(busy1), 0);

    // abort at vector 40
    launch(0);
    wait_vec(40);
    void'(q1.pop_back());
    void'(q2.pop_back());
    a.is_abort = 1'b1; a.err = 0; a.fv = 1'b0; a.fvec = 0; a.pass = 1'b0; a.acc = 0; a.lat = 0;
    q1.push_back(a);
    q2.push_back(a);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_now_busy1", int'(busy1), 0);
    chk("abort_now_ab1", int'(ab1), 1);
    chk("abort_hold_vec1", int'(vec1), 40);
    chk("abort_now_ab2", int'(ab2), 1);
    last_vec = 40;
    repeat (5) @(negedge clk);
    chk("abort_no_done1", int'(done1), 0);
    chk("abort_q_drained", q1.size() + q2.size(), 0);

    // clean sweep after abort
    launch(0);
    chk("restart_ab1", int'(ab1), 0);
    wait_sweeps(1'b0);
    // registered DUT again, now with a held vector of 127
    launch(2);
    wait_sweeps(1'b0);

    chk("final_queue1", q1.size(), 0);
    chk("final_queue2", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
